// File: rtl/param_bank_pkg.sv
// ============================================================================
// Module  : param_bank_pkg
// Brief   : Shared sizing constants, repeat FSM states and default table.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package param_bank_pkg;

   localparam int DEF_FX_COUNT     = 16;
   localparam int DEF_PARAM_COUNT  = 8;
   localparam int DEF_PARAM_W      = 8;
   localparam int DEF_PARAM_MIN    = 0;
   localparam int DEF_PARAM_MAX    = 255;
   localparam int DEF_STEP         = 2;
   localparam int DEF_REPEAT_START = 15_000_000;
   localparam int DEF_REPEAT_RATE  = 2_000_000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_e;

   // Factory preset per (slot, parameter); anything not listed powers up at 0.
   function automatic int default_val(input int fx, input int p);
      int v;
      v = 0;
      case (fx)
         0: case (p)
               0: v = 127;
               1: v = 64;
               2: v = 200;
               default: v = 0;
            endcase
         1: case (p)
               0: v = 100;
               1: v = 40;
               default: v = 0;
            endcase
         2: case (p)
               0: v = 10;
               default: v = 0;
            endcase
         3: case (p)
               1: v = 4;
               2: v = 50;
               default: v = 0;
            endcase
         7: case (p)
               7: v = 255;
               default: v = 0;
            endcase
         default: v = 0;
      endcase
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/param_repeat.sv
// ============================================================================
// Module  : param_repeat
// Brief   : Press / hold / auto-repeat sequencer emitting step pulses.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module param_repeat
   import param_bank_pkg::*;
#(
   parameter int REPEAT_START = DEF_REPEAT_START,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
   input  logic clk,
   input  logic reset_n,
   input  logic inc_i,
   input  logic dec_i,
   input  logic sel_chg_i,
   input  logic clear_i,
   input  logic block_i,
   output logic step_o,
   output logic up_o
);

   localparam int c_cnt_max = (REPEAT_START > REPEAT_RATE) ? REPEAT_START : REPEAT_RATE;
   localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
   localparam logic [c_cnt_w-1:0] c_start_last = c_cnt_w'(REPEAT_START - 1);
   localparam logic [c_cnt_w-1:0] c_rate_last  = c_cnt_w'(REPEAT_RATE - 1);

   rep_state_e           state_q, state_d;
   logic [c_cnt_w-1:0]   cnt_q, cnt_d;
   logic                 up_q, up_d;
   logic                 inc_prev_q, dec_prev_q;
   logic                 w_rise_inc, w_rise_dec, w_held, w_step;

   assign w_rise_inc = inc_i & ~inc_prev_q;
   assign w_rise_dec = dec_i & ~dec_prev_q;
   assign w_held     = up_q ? (inc_i & ~dec_i) : (dec_i & ~inc_i);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         up_q       <= 1'b0;
         inc_prev_q <= 1'b0;
         dec_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         up_q       <= up_d;
         inc_prev_q <= inc_i;
         dec_prev_q <= dec_i;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      up_d    = up_q;
      w_step  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (w_rise_inc && !dec_i) begin
               w_step  = 1'b1;
               up_d    = 1'b1;
               state_d = ST_HOLD;
            end else if (w_rise_dec && !inc_i) begin
               w_step  = 1'b1;
               up_d    = 1'b0;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!w_held || sel_chg_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == c_start_last) begin
               w_step  = 1'b1;
               state_d = ST_REPEAT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_REPEAT: begin
            if (!w_held || sel_chg_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == c_rate_last) begin
               w_step = 1'b1;
               cnt_d  = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      // Restores and sweeps cancel any press; a fresh edge is needed afterwards.
      if (clear_i || block_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         w_step  = 1'b0;
      end
   end

   assign step_o = w_step;
   assign up_o   = up_d;

endmodule

`default_nettype wire

// File: rtl/param_bank.sv
// ============================================================================
// Module  : param_bank
// Brief   : Effect parameter store with clamped stepping and default restore.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module param_bank
   import param_bank_pkg::*;
#(
   parameter int FX_COUNT     = DEF_FX_COUNT,
   parameter int PARAM_COUNT  = DEF_PARAM_COUNT,
   parameter int PARAM_W      = DEF_PARAM_W,
   parameter int PARAM_MIN    = DEF_PARAM_MIN,
   parameter int PARAM_MAX    = DEF_PARAM_MAX,
   parameter int STEP         = DEF_STEP,
   parameter int REPEAT_START = DEF_REPEAT_START,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [$clog2(FX_COUNT)-1:0]    fx_sel,
   input  logic [$clog2(PARAM_COUNT)-1:0] param_sel,
   input  logic                           inc_i,
   input  logic                           dec_i,
   input  logic                           dflt_i,
   input  logic                           dflt_all_i,
   input  logic [$clog2(FX_COUNT)-1:0]    rd_fx,
   input  logic [$clog2(PARAM_COUNT)-1:0] rd_param,
   output logic [PARAM_W-1:0]             rd_data_o,
   output logic [PARAM_W-1:0]             sel_val_o,
   output logic                           changed_o,
   output logic                           busy_o
);

   localparam int c_fx_w = $clog2(FX_COUNT);
   localparam int c_p_w  = $clog2(PARAM_COUNT);
   localparam logic [PARAM_W:0] c_step_x  = (PARAM_W+1)'(STEP);
   localparam logic [PARAM_W:0] c_max_x   = (PARAM_W+1)'(PARAM_MAX);
   localparam logic [PARAM_W:0] c_min_x   = (PARAM_W+1)'(PARAM_MIN);
   localparam logic [PARAM_W:0] c_floor_x = (PARAM_W+1)'(PARAM_MIN + STEP);
   localparam logic [c_fx_w-1:0] c_fx_last = c_fx_w'(FX_COUNT - 1);
   localparam logic [c_p_w-1:0]  c_p_last  = c_p_w'(PARAM_COUNT - 1);

   logic [PARAM_W-1:0] mem_q [FX_COUNT][PARAM_COUNT];

   logic [PARAM_W-1:0] rd_data_q, rd_data_d;
   logic [PARAM_W-1:0] sel_val_q, sel_val_d;
   logic               changed_q, changed_d;
   logic               busy_q, busy_d;
   logic [c_fx_w-1:0]  sw_fx_q, sw_fx_d, fx_prev_q;
   logic [c_p_w-1:0]   sw_p_q, sw_p_d, p_prev_q;

   logic               w_wr_en;
   logic [c_fx_w-1:0]  w_wr_fx;
   logic [c_p_w-1:0]   w_wr_p;
   logic [PARAM_W-1:0] w_wr_data;
   logic [PARAM_W-1:0] w_cur_val, w_sel_dflt, w_sw_dflt, w_stepped;
   logic [PARAM_W:0]   w_ext, w_sum, w_diff;
   logic               w_sel_chg, w_step, w_up;

   assign w_cur_val  = mem_q[fx_sel][param_sel];
   assign w_sel_dflt = PARAM_W'(default_val(32'(fx_sel), 32'(param_sel)));
   assign w_sw_dflt  = PARAM_W'(default_val(32'(sw_fx_q), 32'(sw_p_q)));
   assign w_sel_chg  = (fx_sel != fx_prev_q) || (param_sel != p_prev_q);

   param_repeat #(
      .REPEAT_START (REPEAT_START),
      .REPEAT_RATE  (REPEAT_RATE)
   ) u_repeat (
      .clk       (clk),
      .reset_n   (reset_n),
      .inc_i     (inc_i),
      .dec_i     (dec_i),
      .sel_chg_i (w_sel_chg),
      .clear_i   (dflt_i | dflt_all_i),
      .block_i   (busy_q),
      .step_o    (w_step),
      .up_o      (w_up)
   );

   // One guard bit keeps the saturating compare free of wrap-around.
   always_comb begin
      w_ext  = {1'b0, w_cur_val};
      w_sum  = w_ext + c_step_x;
      w_diff = w_ext - c_step_x;
      if (w_up) begin
         w_stepped = (w_sum > c_max_x) ? c_max_x[PARAM_W-1:0] : w_sum[PARAM_W-1:0];
      end else begin
         w_stepped = (w_ext < c_floor_x) ? c_min_x[PARAM_W-1:0] : w_diff[PARAM_W-1:0];
      end
   end

   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_fx   = fx_sel;
      w_wr_p    = param_sel;
      w_wr_data = w_cur_val;
      busy_d    = busy_q;
      sw_fx_d   = sw_fx_q;
      sw_p_d    = sw_p_q;
      changed_d = 1'b0;
      if (busy_q) begin
         w_wr_en   = 1'b1;
         w_wr_fx   = sw_fx_q;
         w_wr_p    = sw_p_q;
         w_wr_data = w_sw_dflt;
         if (sw_p_q == c_p_last) begin
            sw_p_d  = '0;
            sw_fx_d = sw_fx_q + 1'b1;
            if (sw_fx_q == c_fx_last) begin
               busy_d    = 1'b0;
               changed_d = 1'b1;
            end
         end else begin
            sw_p_d = sw_p_q + 1'b1;
         end
      end else if (dflt_all_i) begin
         busy_d  = 1'b1;
         sw_fx_d = '0;
         sw_p_d  = '0;
      end else if (dflt_i) begin
         w_wr_en   = 1'b1;
         w_wr_data = w_sel_dflt;
         changed_d = (w_sel_dflt != w_cur_val);
      end else if (w_step) begin
         w_wr_en   = 1'b1;
         w_wr_data = w_stepped;
         changed_d = (w_stepped != w_cur_val);
      end
      rd_data_d = mem_q[rd_fx][rd_param];
      sel_val_d = w_cur_val;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int f = 0; f < FX_COUNT; f++) begin
            for (int p = 0; p < PARAM_COUNT; p++) begin
               mem_q[f][p] <= PARAM_W'(default_val(f, p));
            end
         end
      end else if (w_wr_en) begin
         mem_q[w_wr_fx][w_wr_p] <= w_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_data_q <= '0;
         sel_val_q <= '0;
         changed_q <= 1'b0;
         busy_q    <= 1'b0;
         sw_fx_q   <= '0;
         sw_p_q    <= '0;
         fx_prev_q <= '0;
         p_prev_q  <= '0;
      end else begin
         rd_data_q <= rd_data_d;
         sel_val_q <= sel_val_d;
         changed_q <= changed_d;
         busy_q    <= busy_d;
         sw_fx_q   <= sw_fx_d;
         sw_p_q    <= sw_p_d;
         fx_prev_q <= fx_sel;
         p_prev_q  <= param_sel;
      end
   end

   assign rd_data_o = rd_data_q;
   assign sel_val_o = sel_val_q;
   assign changed_o = changed_q;
   assign busy_o    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_param_bank.sv
// ============================================================================
// Module  : tb_param_bank
// Brief   : Scoreboarded directed bench for param_bank (short repeat timing).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_param_bank;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] fx_sel, rd_fx;
   logic [2:0] param_sel, rd_param;
   logic       inc_i, dec_i, dflt_i, dflt_all_i;
   logic [7:0] rd_data_o, sel_val_o;
   logic       changed_o, busy_o;

   always #5 clk = ~clk;

   param_bank #(
      .FX_COUNT     (16),
      .PARAM_COUNT  (8),
      .PARAM_W      (8),
      .PARAM_MIN    (0),
      .PARAM_MAX    (255),
      .STEP         (2),
      .REPEAT_START (10),
      .REPEAT_RATE  (3)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .fx_sel     (fx_sel),
      .param_sel  (param_sel),
      .inc_i      (inc_i),
      .dec_i      (dec_i),
      .dflt_i     (dflt_i),
      .dflt_all_i (dflt_all_i),
      .rd_fx      (rd_fx),
      .rd_param   (rd_param),
      .rd_data_o  (rd_data_o),
      .sel_val_o  (sel_val_o),
      .changed_o  (changed_o),
      .busy_o     (busy_o)
   );

   typedef struct {
      string name;
      int    val;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic push(input string name, input int val);
      exp_t e;
      e.name = name;
      e.val  = val;
      sb.push_back(e);
   endtask

   // Each changed_o pulse consumes one expectation; the written value is seen
   // on sel_val_o one cycle after the pulse.
   initial begin : monitor
      bit   pend;
      exp_t cur;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         if (pend) begin
            pend = 1'b0;
            check(cur.name, int'(sel_val_o), cur.val);
         end
         if (changed_o === 1'b1) begin
            if (sb.size() == 0) begin
               check("changed_o_unexpected", int'(changed_o), 0);
            end else begin
               cur  = sb.pop_front();
               pend = 1'b1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sel(input int f, input int p);
      fx_sel    = 4'(f);
      param_sel = 3'(p);
      tick();
      tick();
   endtask

   task automatic press_inc();
      inc_i = 1'b1;
      tick();
      inc_i = 1'b0;
      tick();
   endtask

   task automatic press_dec();
      dec_i = 1'b1;
      tick();
      dec_i = 1'b0;
      tick();
   endtask

   task automatic rd(input string name, input int f, input int p, input int exp);
      rd_fx    = 4'(f);
      rd_param = 3'(p);
      tick();
      check(name, int'(rd_data_o), exp);
   endtask

   initial begin : timeout
      #2_000_000;
      $display("FAIL timeout: simulation still running, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int cnt;
      int guard;
      reset_n    = 1'b0;
      fx_sel     = '0;
      param_sel  = '0;
      rd_fx      = '0;
      rd_param   = '0;
      inc_i      = 1'b0;
      dec_i      = 1'b0;
      dflt_i     = 1'b0;
      dflt_all_i = 1'b0;
      tick();
      tick();
      check("reset_rd_data", int'(rd_data_o), 0);
      check("reset_sel_val", int'(sel_val_o), 0);
      check("reset_busy", int'(busy_o), 0);
      check("reset_changed", int'(changed_o), 0);
      reset_n = 1'b1;
      tick();

      rd("dflt_fx0_p0", 0, 0, 127);
      rd("dflt_fx1_p1", 1, 1, 40);
      rd("dflt_fx5_p3", 5, 3, 0);

      // Hold inc for 20 cycles: steps at cycles 1, 11, 14, 17, 20.
      sel(3, 1);
      check("sel_fx3_p1", int'(sel_val_o), 4);
      push("hold_step1", 6);
      push("hold_step2", 8);
      push("hold_step3", 10);
      push("hold_step4", 12);
      push("hold_step5", 14);
      inc_i = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 11) check("hold_before_repeat", int'(sel_val_o), 6);
         if (c == 12) check("hold_first_repeat", int'(sel_val_o), 8);
      end
      inc_i = 1'b0;
      tick();
      tick();
      tick();
      check("hold_release", int'(sel_val_o), 14);

      // Walk fx2/p0 from 10 up to the ceiling and back down to the floor.
      sel(2, 0);
      for (int k = 1; k <= 122; k++) begin
         push("inc_walk", 10 + 2 * k);
         press_inc();
      end
      push("inc_clamp_255", 255);
      press_inc();
      press_inc();
      check("inc_at_max", int'(sel_val_o), 255);
      for (int k = 1; k <= 127; k++) begin
         push("dec_walk", 255 - 2 * k);
         press_dec();
      end
      push("dec_clamp_0", 0);
      press_dec();
      rd("dec_floor", 2, 0, 0);

      // Both buttons high, then second button joining mid-hold.
      sel(3, 1);
      inc_i = 1'b1;
      dec_i = 1'b1;
      repeat (15) tick();
      inc_i = 1'b0;
      dec_i = 1'b0;
      tick();
      check("both_high_nochange", int'(sel_val_o), 14);
      push("inc_then_both", 16);
      inc_i = 1'b1;
      repeat (3) tick();
      dec_i = 1'b1;
      repeat (15) tick();
      inc_i = 1'b0;
      dec_i = 1'b0;
      tick();
      check("both_mid_hold", int'(sel_val_o), 16);

      // Selection change mid-hold stops repeating on either entry.
      push("selchg_first", 18);
      inc_i = 1'b1;
      repeat (4) tick();
      param_sel = 3'd2;
      repeat (20) tick();
      inc_i = 1'b0;
      tick();
      tick();
      rd("selchg_old_entry", 3, 1, 18);
      rd("selchg_new_entry", 3, 2, 50);

      // Restore beats a simultaneous step and cancels the hold.
      sel(0, 0);
      push("pre_dflt_inc", 129);
      press_inc();
      push("dflt_over_inc", 127);
      inc_i  = 1'b1;
      dflt_i = 1'b1;
      tick();
      dflt_i = 1'b0;
      repeat (15) tick();
      inc_i = 1'b0;
      tick();
      tick();
      check("dflt_no_repeat", int'(sel_val_o), 127);
      sel(3, 1);
      push("dflt_single", 4);
      dflt_i = 1'b1;
      tick();
      dflt_i = 1'b0;
      tick();
      tick();

      // Bulk restore with stray inputs while busy.
      sel(1, 1);
      push("pre_sweep_dec", 38);
      press_dec();
      rd_fx    = 4'd7;
      rd_param = 3'd7;
      push("sweep_end", 40);
      dflt_all_i = 1'b1;
      tick();
      dflt_all_i = 1'b0;
      cnt   = 0;
      guard = 0;
      while (busy_o === 1'b1 && guard < 400) begin
         cnt++;
         guard++;
         inc_i      = (cnt == 5);
         dflt_i     = (cnt == 10);
         dflt_all_i = (cnt == 30);
         tick();
         if (cnt == 60) check("rd_during_sweep", int'(rd_data_o), 255);
      end
      inc_i      = 1'b0;
      dflt_i     = 1'b0;
      dflt_all_i = 1'b0;
      check("sweep_busy_cycles", cnt, 128);
      tick();
      tick();
      tick();
      rd("sweep_fx0_p0", 0, 0, 127);
      rd("sweep_fx1_p1", 1, 1, 40);
      rd("sweep_fx2_p0", 2, 0, 10);
      rd("sweep_fx3_p1", 3, 1, 4);
      rd("sweep_fx3_p2", 3, 2, 50);

      // Reset in the middle of a sweep.
      sel(5, 3);
      push("pre_reset_inc", 2);
      press_inc();
      dflt_all_i = 1'b1;
      tick();
      dflt_all_i = 1'b0;
      repeat (20) tick();
      check("mid_sweep_busy", int'(busy_o), 1);
      reset_n = 1'b0;
      tick();
      check("abort_busy", int'(busy_o), 0);
      check("abort_changed", int'(changed_o), 0);
      check("abort_sel_val", int'(sel_val_o), 0);
      reset_n = 1'b1;
      tick();
      rd("abort_fx5_p3", 5, 3, 0);
      rd("abort_fx0_p0", 0, 0, 127);
      rd("abort_fx1_p1", 1, 1, 40);
      repeat (5) tick();
      check("abort_busy_stays_low", int'(busy_o), 0);
      check("sb_drain", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/param_bank.md
PARAM_BANK -- requirements
Module: param_bank

Interface
REQ-001 SHALL take parameter FX_COUNT, default 16, number of effect slots.
REQ-002 SHALL take parameter PARAM_COUNT, default 8, parameters per slot.
REQ-003 SHALL take parameter PARAM_W, default 8, parameter value width.
REQ-004 SHALL take parameters PARAM_MIN, default 0, and PARAM_MAX, default 255; these are the saturation bounds.
REQ-005 SHALL take parameter STEP, default 2, increment/decrement amount.
REQ-006 SHALL take parameter REPEAT_START, default 15_000_000, hold cycles before auto-repeat begins.
REQ-007 SHALL take parameter REPEAT_RATE, default 2_000_000, cycles between repeats.
REQ-008 Ports SHALL be as follows. One clock; reset is synchronous and active-low.
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- fx_sel  in  $clog2(FX_COUNT)  edited slot
- param_sel  in  $clog2(PARAM_COUNT)  edited parameter
- inc_i  in  1  debounced increment level
- dec_i  in  1  debounced decrement level
- dflt_i  in  1  pulse: restore selected entry to default
- dflt_all_i  in  1  pulse: restore all entries
- rd_fx  in  $clog2(FX_COUNT)  DSP read slot
- rd_param  in  $clog2(PARAM_COUNT)  DSP read parameter
- rd_data_o  out  PARAM_W  read data
- sel_val_o  out  PARAM_W  value of the selected entry, for display
- changed_o  out  1  one-cycle pulse on any write
- busy_o  out  1  bulk-restore sweep in progress

Function
REQ-009 Storage SHALL be a FX_COUNT x PARAM_COUNT register array of PARAM_W bits; entries with no table default SHALL be 0.
REQ-010 rd_data_o and sel_val_o SHALL be registered, one-cycle latency from address/selection; a write and a read of the same entry in one cycle SHALL return the old value.
REQ-011 Step arithmetic SHALL be computed at PARAM_W+1 bits and clamped: inc gives min(v+STEP, PARAM_MAX); dec gives max(v-STEP, PARAM_MIN); no wrap.
REQ-012 The repeat FSM SHALL have the states IDLE, HOLD and REPEAT, plus a cycle counter.
REQ-013 IDLE -> HOLD on a rising edge of exactly one of inc_i/dec_i; one step SHALL be applied in that cycle.
REQ-014 In HOLD, after REPEAT_START cycles still held, the FSM SHALL apply a step and go to REPEAT.
REQ-015 In REPEAT, the FSM SHALL apply a step every REPEAT_RATE cycles while held.
REQ-016 Releasing the button, inc_i and dec_i both high, or a change of fx_sel/param_sel SHALL return the FSM to IDLE with no step; a new rising edge SHALL be required.
REQ-017 A step at the bound SHALL leave the value unchanged and SHALL NOT pulse changed_o.
REQ-018 dflt_i SHALL write the default of the selected entry in the next cycle; it SHALL take priority over an inc/dec step in the same cycle and SHALL force the FSM to IDLE.
REQ-019 dflt_all_i SHALL start a sweep writing one entry per cycle, FX_COUNT*PARAM_COUNT cycles in total.
REQ-020 busy_o SHALL be high for the whole sweep; inc_i, dec_i, dflt_i and dflt_all_i SHALL be ignored while busy_o is high; reads SHALL remain valid.
REQ-021 changed_o SHALL pulse for each value-changing single write and once at the end of a sweep.

Reset
REQ-022 On reset_n=0 at a clock edge, all entries SHALL load their defaults, the FSM SHALL go to IDLE, counters SHALL clear, busy_o, changed_o, rd_data_o and sel_val_o SHALL be 0, and any sweep in progress SHALL be aborted.

Structure
REQ-023 The default-value function, FX_COUNT, PARAM_COUNT, PARAM_W, bounds and repeat constants SHALL live in the shared package; the FSM state enum SHALL live there too.
REQ-024 The repeat FSM SHALL be one sub-module, param_repeat, producing a step-pulse and direction; param_bank SHALL own storage and the sweep.

Verification (REPEAT_START=10, REPEAT_RATE=3, STEP=2)
REQ-025 After reset, entry fx0/p0 SHALL read 127, fx1/p1 SHALL read 40, and fx5/p3 SHALL read 0.
REQ-026 Hold inc_i for 20 cycles on fx3/p1 (value 4): expect 6 in cycle 1, 8 at cycle 11, then 10, 12 and 14 every 3 cycles; release leaves 14.
REQ-027 Set fx2/p0 to 254 and press inc: result 255; press again: stays 255 with no changed_o. Set it to 1 and press dec: result 0.
REQ-028 With inc_i and dec_i both high, no change; changing param_sel mid-hold stops repeat.
REQ-029 Pulse dflt_all_i after edits: busy_o high for 128 cycles, inc ignored, all defaults restored, and exactly one changed_o at the end.
REQ-030 Assert reset_n=0 mid-sweep: next cycle busy_o=0 and all entries are at default.
